// File: rtl/vx_mp_ram_pkg.sv
// Shared types and helpers for the multi-read-port RAM: FSM state encoding
// and the lane merge used by both the write path and the read forward path.
package vx_mp_ram_pkg;

    typedef enum logic {
        MP_RAM_INIT  = 1'b0,
        MP_RAM_READY = 1'b1
    } mp_ram_state_e;

    // Widest word the merge helper handles; callers widen their operands and
    // size-cast the result back to DATAW.
    localparam int MP_RAM_MAXW = 1024;

    typedef logic [MP_RAM_MAXW-1:0] mp_ram_word_t;

    // Bits selected by wmask come from new_w, all others keep old_w.
    function automatic mp_ram_word_t lane_merge(
        input mp_ram_word_t old_w,
        input mp_ram_word_t new_w,
        input mp_ram_word_t wmask
    );
        return (old_w & ~wmask) | (new_w & wmask);
    endfunction

endpackage

// File: rtl/vx_mp_ram_rport.sv
// One read port: same-cycle write forwarding plus an optional output
// register with a one-cycle valid pulse per accepted read.
module vx_mp_ram_rport
    import vx_mp_ram_pkg::*;
#(
    parameter int DATAW     = 32,
    parameter int ADDRW     = 6,
    parameter int OUT_REG   = 0,
    parameter int RW_BYPASS = 1
)(
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             ready_i,
    input  logic             read_i,
    input  logic [ADDRW-1:0] raddr_i,
    input  logic [DATAW-1:0] rd_word_i,
    input  logic             fwd_en_i,
    input  logic [ADDRW-1:0] waddr_i,
    input  logic [DATAW-1:0] wdata_i,
    input  logic [DATAW-1:0] wmask_i,
    output logic [DATAW-1:0] rdata_o,
    output logic             rvalid_o
);

    logic             active;
    logic             hit;
    logic [DATAW-1:0] fwd_word;

    assign active   = ready_i & read_i;
    assign hit      = (RW_BYPASS != 0) && fwd_en_i && (raddr_i == waddr_i);
    assign fwd_word = hit ? DATAW'(lane_merge(mp_ram_word_t'(rd_word_i),
                                              mp_ram_word_t'(wdata_i),
                                              mp_ram_word_t'(wmask_i)))
                          : rd_word_i;

    generate
        if (OUT_REG != 0) begin : g_reg
            logic [DATAW-1:0] rdata_q;
            logic [DATAW-1:0] rdata_d;
            logic             rvalid_q;

            // Idle ports keep presenting the last word they returned.
            assign rdata_d = active ? fwd_word : rdata_q;

            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rdata_q  <= rdata_d;
                    rvalid_q <= active;
                end
            end

            assign rdata_o  = rdata_q;
            assign rvalid_o = rvalid_q;
        end else begin : g_comb
            logic unused_clk_rst;
            assign unused_clk_rst = &{1'b0, clk_i, reset_n_i};
            assign rdata_o  = fwd_word;
            assign rvalid_o = active;
        end
    endgenerate

endmodule

// File: rtl/vx_mp_ram.sv
// Multi-read-port RAM with lane write enables, per-port forwarding and a
// hardware sweep that fills every word with INIT_VALUE after reset/init_req.
module vx_mp_ram
    import vx_mp_ram_pkg::*;
#(
    parameter int               DATAW      = 32,
    parameter int               SIZE       = 64,
    parameter int               WRENW      = 4,
    parameter int               NUM_RPORTS = 2,
    parameter int               OUT_REG    = 0,
    parameter int               RW_BYPASS  = 1,
    parameter logic [DATAW-1:0] INIT_VALUE = '0,
    parameter int               ADDRW      = (SIZE > 1) ? $clog2(SIZE) : 1
)(
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          init_req_i,
    output logic                          ready_o,
    input  logic                          write_i,
    input  logic [WRENW-1:0]              wren_i,
    input  logic [ADDRW-1:0]              waddr_i,
    input  logic [DATAW-1:0]              wdata_i,
    input  logic [NUM_RPORTS-1:0]         read_i,
    input  logic [NUM_RPORTS*ADDRW-1:0]   raddr_i,
    output logic [NUM_RPORTS*DATAW-1:0]   rdata_o,
    output logic [NUM_RPORTS-1:0]         rvalid_o
);

    localparam int               WSELW     = DATAW / WRENW;
    localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(SIZE - 1);

    mp_ram_state_e    state_q;
    logic [ADDRW-1:0] cnt_q;
    logic             ready_q;

    logic [DATAW-1:0] mem_q [SIZE];
    logic [DATAW-1:0] wr_mask;
    logic [DATAW-1:0] user_word;
    logic             user_we;

    generate
        for (genvar gi = 0; gi < WRENW; gi++) begin : g_mask
            assign wr_mask[gi*WSELW +: WSELW] = {WSELW{wren_i[gi]}};
        end
    endgenerate

    // Sweep counter stops at SIZE-1, so non-power-of-two sizes never wrap.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= MP_RAM_INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                MP_RAM_INIT: begin
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= MP_RAM_READY;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                MP_RAM_READY: begin
                    if (init_req_i) begin
                        state_q <= MP_RAM_INIT;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= MP_RAM_INIT;
                    cnt_q   <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o   = ready_q;
    assign user_we   = (state_q == MP_RAM_READY) & write_i & (|wren_i);
    assign user_word = DATAW'(lane_merge(mp_ram_word_t'(mem_q[waddr_i]),
                                         mp_ram_word_t'(wdata_i),
                                         mp_ram_word_t'(wr_mask)));

    // Storage is never reset; the sweep owns the write port while in INIT.
    always_ff @(posedge clk_i) begin
        if (state_q == MP_RAM_INIT) begin
            mem_q[cnt_q] <= INIT_VALUE;
        end else if (user_we) begin
            mem_q[waddr_i] <= user_word;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_RPORTS; gi++) begin : g_rport
            logic [DATAW-1:0] rd_word;
            assign rd_word = mem_q[raddr_i[gi*ADDRW +: ADDRW]];

            vx_mp_ram_rport #(
                .DATAW     (DATAW),
                .ADDRW     (ADDRW),
                .OUT_REG   (OUT_REG),
                .RW_BYPASS (RW_BYPASS)
            ) u_rport (
                .clk_i     (clk_i),
                .reset_n_i (reset_n_i),
                .ready_i   (ready_q),
                .read_i    (read_i[gi]),
                .raddr_i   (raddr_i[gi*ADDRW +: ADDRW]),
                .rd_word_i (rd_word),
                .fwd_en_i  (user_we),
                .waddr_i   (waddr_i),
                .wdata_i   (wdata_i),
                .wmask_i   (wr_mask),
                .rdata_o   (rdata_o[gi*DATAW +: DATAW]),
                .rvalid_o  (rvalid_o[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_vx_mp_ram.sv
// Directed bench: three RAM variants share one stimulus stream
// (a: registered+bypass, b: combinational no-bypass, c: registered no-bypass).
module tb_vx_mp_ram;

    localparam logic [31:0] A5 = 32'hA5A5A5A5;
    localparam logic [31:0] LM = 32'hA522A544;
    localparam logic [31:0] DB = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        init_req;
    logic        write;
    logic [3:0]  wren;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [2:0]  read;
    logic [11:0] raddr;

    logic        ready_a, ready_b, ready_c;
    logic [95:0] rdata_a, rdata_b;
    logic [31:0] rdata_c;
    logic [2:0]  rvalid_a, rvalid_b;
    logic        rvalid_c;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vx_mp_ram #(.DATAW(32), .SIZE(16), .WRENW(4), .NUM_RPORTS(3), .OUT_REG(1),
                .RW_BYPASS(1), .INIT_VALUE(32'hA5A5A5A5)) dut_a (
        .clk_i(clk), .reset_n_i(reset_n), .init_req_i(init_req), .ready_o(ready_a),
        .write_i(write), .wren_i(wren), .waddr_i(waddr), .wdata_i(wdata),
        .read_i(read), .raddr_i(raddr), .rdata_o(rdata_a), .rvalid_o(rvalid_a));

    vx_mp_ram #(.DATAW(32), .SIZE(16), .WRENW(4), .NUM_RPORTS(3), .OUT_REG(0),
                .RW_BYPASS(0), .INIT_VALUE(32'hA5A5A5A5)) dut_b (
        .clk_i(clk), .reset_n_i(reset_n), .init_req_i(init_req), .ready_o(ready_b),
        .write_i(write), .wren_i(wren), .waddr_i(waddr), .wdata_i(wdata),
        .read_i(read), .raddr_i(raddr), .rdata_o(rdata_b), .rvalid_o(rvalid_b));

    vx_mp_ram #(.DATAW(32), .SIZE(16), .WRENW(4), .NUM_RPORTS(1), .OUT_REG(1),
                .RW_BYPASS(0), .INIT_VALUE(32'hA5A5A5A5)) dut_c (
        .clk_i(clk), .reset_n_i(reset_n), .init_req_i(init_req), .ready_o(ready_c),
        .write_i(write), .wren_i(wren), .waddr_i(waddr), .wdata_i(wdata),
        .read_i(read[0:0]), .raddr_i(raddr[3:0]), .rdata_o(rdata_c), .rvalid_o(rvalid_c));

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep_wait(input string tag);
        for (int i = 1; i <= 16; i++) begin
            cyc();
            chk({tag, "_ready"}, 96'({ready_a, ready_b, ready_c}), (i == 16) ? 96'h7 : 96'h0);
            chk({tag, "_rvalid_reg"}, 96'({rvalid_a, rvalid_c}), 96'h0);
            chk({tag, "_rvalid_comb"}, 96'(rvalid_b), (i == 16) ? 96'(read) : 96'h0);
            if (i < 15) init_req = init_req; else init_req = 1'b0;
        end
    endtask

    initial begin
        reset_n = 1'b0; init_req = 1'b0; write = 1'b0; wren = 4'h0;
        waddr = 4'd0; wdata = 32'h0; read = 3'b111; raddr = 12'h0;

        repeat (3) cyc();
        chk("rst_ready", 96'({ready_a, ready_b, ready_c}), 96'h0);
        chk("rst_rvalid", 96'({rvalid_a, rvalid_b, rvalid_c}), 96'h0);
        chk("rst_rdata_a", rdata_a, 96'h0);
        chk("rst_rdata_c", 96'(rdata_c), 96'h0);

        // Reads held high through the sweep must all be ignored.
        reset_n = 1'b1;
        sweep_wait("sweep");
        read = 3'b000;

        for (int a = 0; a < 16; a++) begin
            read  = 3'b111;
            raddr = {4'(a), 4'(15 - a), 4'(a)};
            #1;
            chk("sweep_rd_b", rdata_b, {A5, A5, A5});
            cyc();
            chk("sweep_rd_a", rdata_a, {A5, A5, A5});
            chk("sweep_rd_c", 96'(rdata_c), 96'(A5));
            chk("sweep_rvalid_a", 96'(rvalid_a), 96'h7);
        end
        read = 3'b000;
        cyc();
        chk("idle_rvalid", 96'({rvalid_a, rvalid_c}), 96'h0);
        chk("idle_hold_a", rdata_a, {A5, A5, A5});

        // Lane write to addr 3 with concurrent reads of 3, 3, 0.
        write = 1'b1; wren = 4'b0101; waddr = 4'd3; wdata = 32'h11223344;
        read = 3'b111; raddr = {4'd0, 4'd3, 4'd3};
        #1;
        chk("lane_nobyp_b", rdata_b, {A5, A5, A5});
        chk("lane_rvalid_b", 96'(rvalid_b), 96'h7);
        cyc();
        chk("lane_fwd_a", rdata_a, {A5, LM, LM});
        chk("lane_nobyp_c", 96'(rdata_c), 96'(A5));
        chk("mp_rvalid_a", 96'(rvalid_a), 96'h7);
        write = 1'b0; read = 3'b010; raddr = {4'd0, 4'd3, 4'd0};
        #1;
        chk("lane_vis_b", rdata_b, {A5, LM, A5});
        cyc();
        chk("mp_rvalid_once", 96'({rvalid_a, rvalid_c}), 96'h4);
        chk("lane_hold_a", rdata_a, {A5, LM, LM});
        chk("lane_hold_c", 96'(rdata_c), 96'(A5));
        read = 3'b000;
        cyc();
        chk("mp_rvalid_off", 96'(rvalid_a), 96'h0);

        // Full-word write to addr 7 forwarded only where bypass is enabled.
        write = 1'b1; wren = 4'hF; waddr = 4'd7; wdata = DB;
        read = 3'b001; raddr = {4'd0, 4'd0, 4'd7};
        #1;
        chk("fwd_off_b", 96'(rdata_b[31:0]), 96'(A5));
        cyc();
        chk("fwd_on_a", 96'(rdata_a[31:0]), 96'(DB));
        chk("fwd_off_c", 96'(rdata_c), 96'(A5));
        chk("fwd_rvalid", 96'({rvalid_a, rvalid_c}), 96'h3);
        write = 1'b0;
        #1;
        chk("wr_vis_b", 96'(rdata_b[31:0]), 96'(DB));
        cyc();
        chk("wr_vis_c", 96'(rdata_c), 96'(DB));

        // Write with no lanes enabled changes nothing.
        write = 1'b1; wren = 4'h0; wdata = 32'h0;
        cyc();
        chk("wren0_fwd_a", 96'(rdata_a[31:0]), 96'(DB));
        write = 1'b0;
        #1;
        chk("wren0_b", 96'(rdata_b[31:0]), 96'(DB));
        read = 3'b000;

        // Re-init with a concurrent write; traffic during the sweep is ignored.
        write = 1'b1; wren = 4'hF; waddr = 4'd5; wdata = 32'h12345678; init_req = 1'b1;
        cyc();
        chk("reinit_ready", 96'({ready_a, ready_b, ready_c}), 96'h0);
        wdata = 32'h0BADF00D; read = 3'b111; raddr = {4'd5, 4'd5, 4'd5};
        sweep_wait("reinit");
        write = 1'b0;
        #1;
        chk("reinit_rd_b", rdata_b, {A5, A5, A5});
        cyc();
        chk("reinit_rd_a", rdata_a, {A5, A5, A5});
        chk("reinit_rd_c", 96'(rdata_c), 96'(A5));
        chk("reinit_rvalid_a", 96'(rvalid_a), 96'h7);
        read = 3'b000;

        // Reset in the middle of a sweep.
        write = 1'b1; wren = 4'hF; waddr = 4'd7; wdata = DB;
        cyc();
        write = 1'b0; read = 3'b001; raddr = {4'd0, 4'd0, 4'd7}; init_req = 1'b1;
        cyc();
        chk("pre_rst_a", 96'(rdata_a[31:0]), 96'(DB));
        chk("pre_rst_c", 96'(rdata_c), 96'(DB));
        chk("pre_rst_ready", 96'({ready_a, ready_b, ready_c}), 96'h0);
        init_req = 1'b0; read = 3'b000;
        repeat (7) cyc();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ready", 96'({ready_a, ready_b, ready_c}), 96'h0);
        chk("mid_rst_rvalid", 96'({rvalid_a, rvalid_c}), 96'h0);
        chk("mid_rst_rdata_a", rdata_a, 96'h0);
        chk("mid_rst_rdata_c", 96'(rdata_c), 96'h0);
        cyc();
        reset_n = 1'b1;
        sweep_wait("resweep");
        read = 3'b111; raddr = {4'd7, 4'd7, 4'd7};
        #1;
        chk("resweep_rd_b", rdata_b, {A5, A5, A5});
        cyc();
        chk("resweep_rd_a", rdata_a, {A5, A5, A5});
        chk("resweep_rd_c", 96'(rdata_c), 96'(A5));
        read = 3'b000;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
